// File: rtl/tx_link_sequencer.sv
// TX link-layer sequencer feeding the 8b/10b encoder: comma alignment, idle ordered sets, framing.
// Optional clock-compensation insertion is built when TX_CLK_COMP_EN is defined.
module tx_link_sequencer #(
  parameter int ALIGN_COUNT = 16,
  parameter int MAX_FRAME   = 256,
  parameter int CC_PERIOD   = 1024
) (
  input  logic       BitCLK_10,
  input  logic       Reset,
  input  logic       LinkEnable,
  input  logic [7:0] TxData_8,
  input  logic       TxValid,
  input  logic       TxLast,
  output logic       TxReady,
  output logic [7:0] TxParallel_8,
  output logic       TxDataK,
  output logic       LinkUp,
  output logic       FrameErr,
  output logic [2:0] dbgState
);

  // Handshake: a byte is transferred on a rising edge where TxValid && TxReady;
  // TxReady depends only on state, never on TxValid.

  localparam int AlignW = $clog2(ALIGN_COUNT + 1);
  localparam int ByteW  = $clog2(MAX_FRAME + 1);

  if (ALIGN_COUNT < 1 || MAX_FRAME < 1 || CC_PERIOD < 1) begin : gBadParam
    $error("tx_link_sequencer: ALIGN_COUNT, MAX_FRAME and CC_PERIOD must be >= 1");
  end

  typedef enum logic [2:0] {
    ALIGN = 3'd0,
    IDLE  = 3'd1,
    SOF   = 3'd2,
    DATA  = 3'd3,
    EOF   = 3'd4
`ifdef TX_CLK_COMP_EN
    , CC  = 3'd5
`endif
  } state_t;

  state_t            state, stateNext;
  logic [AlignW-1:0] alignCnt, alignCntNext;
  logic [ByteW-1:0]  byteCnt, byteCntNext;
  logic              idlePhase;
  logic              forced, forcedNext;
  logic [7:0]        charNext;
  logic              kNext, errNext;

`ifdef TX_CLK_COMP_EN
  localparam int CcW = $clog2(CC_PERIOD + 1);
  logic [CcW-1:0] ccCnt;
  logic           ccSecond;
  logic           ccDue;

  assign ccDue = (ccCnt >= CcW'(CC_PERIOD));

  // Character counter restarts whenever the link realigns and after each CC pair.
  always_ff @(posedge BitCLK_10) begin
    if (Reset || state == ALIGN) begin
      ccCnt <= '0;
    end else if (state == CC && ccSecond) begin
      ccCnt <= '0;
    end else if (ccCnt != '1) begin
      ccCnt <= ccCnt + 1'b1;
    end
    ccSecond <= !Reset && (state == CC) && !ccSecond;
  end
`endif

  assign dbgState = state;

  always_comb begin
    stateNext    = state;
    alignCntNext = alignCnt;
    byteCntNext  = byteCnt;
    forcedNext   = forced;
    charNext     = 8'hBC;
    kNext        = 1'b1;
    errNext      = 1'b0;
    TxReady      = 1'b0;
    case (state)
      ALIGN: begin
        if (!LinkEnable) begin
          alignCntNext = '0;
        end else if (alignCnt == AlignW'(ALIGN_COUNT - 1)) begin
          alignCntNext = '0;
          stateNext    = IDLE;
        end else begin
          alignCntNext = alignCnt + 1'b1;
        end
      end
      IDLE: begin
        charNext = idlePhase ? 8'h50 : 8'hBC;
        kNext    = !idlePhase;
        if (!LinkEnable) begin
          alignCntNext = '0;
          stateNext    = ALIGN;
        end else if (idlePhase) begin
`ifdef TX_CLK_COMP_EN
          if (ccDue) stateNext = CC;
          else
`endif
          if (TxValid) stateNext = SOF;
        end
      end
      SOF: begin
        charNext    = 8'hFB;
        byteCntNext = '0;
        forcedNext  = 1'b0;
        stateNext   = DATA;
      end
      DATA: begin
        TxReady = 1'b1;
        if (TxValid) begin
          charNext    = TxData_8;
          kNext       = 1'b0;
          byteCntNext = byteCnt + 1'b1;
          // TxLast wins over the length limit, so a full-length frame ends cleanly.
          if (TxLast) begin
            stateNext = EOF;
          end else if (byteCnt == ByteW'(MAX_FRAME - 1)) begin
            forcedNext = 1'b1;
            stateNext  = EOF;
          end
        end else begin
          charNext = 8'hF7;
        end
      end
      EOF: begin
        charNext  = 8'hFD;
        errNext   = forced;
        stateNext = IDLE;
      end
`ifdef TX_CLK_COMP_EN
      CC: begin
        charNext = 8'h1C;
        if (ccSecond) stateNext = IDLE;
      end
`endif
      default: stateNext = ALIGN;
    endcase
  end

  always_ff @(posedge BitCLK_10) begin
    if (Reset) begin
      state        <= ALIGN;
      alignCnt     <= '0;
      idlePhase    <= 1'b0;
      byteCnt      <= '0;
      forced       <= 1'b0;
      TxParallel_8 <= 8'hBC;
      TxDataK      <= 1'b1;
      LinkUp       <= 1'b0;
      FrameErr     <= 1'b0;
    end else begin
      state        <= stateNext;
      alignCnt     <= alignCntNext;
      byteCnt      <= byteCntNext;
      forced       <= forcedNext;
      // Any entry into IDLE starts at phase 0 because every other state clears it.
      idlePhase    <= (state == IDLE) ? !idlePhase : 1'b0;
      TxParallel_8 <= charNext;
      TxDataK      <= kNext;
      LinkUp       <= (state != ALIGN);
      FrameErr     <= errNext;
    end
  end

endmodule

// File: doc/tx_link_sequencer.md
Name: tx_link_sequencer

Overview:
- TX link-layer controller that sequences the 8b/10b encoder input (TxParallel_8/TxDataK) on the BitCLK_10 domain.
- After reset it emits a comma alignment burst, then idle ordered sets.
- It frames user bytes from a valid/ready source with start-of-frame and end-of-frame K-characters.
- It inserts filler on source underflow and force-terminates frames that exceed the maximum length.

Parameters:
ALIGN_COUNT, 16, number of consecutive K28.5 commas sent after reset or link re-enable (>=1)
MAX_FRAME, 256, maximum data bytes per frame before a forced EOF (>=1)
CC_PERIOD, 1024, characters between clock-compensation insertions (only with TX_CLK_COMP_EN)

Ports:
BitCLK_10  in  1  character clock
Reset  in  1  synchronous, active-high reset
LinkEnable  in  1  1 = run link; 0 = drop to alignment when not inside a frame
TxData_8  in  8  user data byte
TxValid  in  1  TxData_8 valid
TxLast  in  1  qualifies the final byte of a frame
TxReady  out  1  block accepts TxData_8 this cycle; combinational = (state==DATA)
TxParallel_8  out  8  character to encoder, registered
TxDataK  out  1  1 = TxParallel_8 is a K-character, registered
LinkUp  out  1  high while in IDLE/SOF/DATA/EOF (/CC), registered
FrameErr  out  1  one-cycle pulse coincident with a forced EOF character

Behaviour:
- Clock and reset: single clock BitCLK_10. Reset is synchronous and active-high; it is sampled on the rising edge and overrides everything, including mid-frame.
- Reset values: state=ALIGN, align counter=0, idle phase=0, byte count=0, TxParallel_8=8'hBC, TxDataK=1, LinkUp=0, FrameErr=0.
- Output timing: the character chosen by the state in cycle n is registered and visible in cycle n+1 (1-cycle latency). An accepted data byte appears on TxParallel_8 the cycle after its handshake.
- ALIGN:
  - Emit 8'hBC K=1 (K28.5) each cycle and increment the counter.
  - After ALIGN_COUNT commas go to IDLE, phase 0. LinkUp rises with the first IDLE character.
  - If LinkEnable=0, hold the counter at 0 and keep emitting commas.
- IDLE:
  - Ordered set: phase 0 emits 8'hBC K=1; phase 1 emits 8'h50 K=0 (D16.2); the phase toggles each cycle.
  - Frames start only on an ordered-set boundary: in phase 1, if TxValid=1 and LinkEnable=1, go to SOF.
  - In IDLE, LinkEnable=0 sends the block to ALIGN with counter cleared and LinkUp=0.
- SOF: emit 8'hFB K=1 (K27.7) for one cycle, clear the byte count, go to DATA.
- DATA:
  - TxReady=1. On TxValid=1, emit TxData_8 K=0 and increment the byte count.
  - On TxValid=0, emit filler 8'hF7 K=1 (K23.7); filler does not count.
  - Accepted byte with TxLast=1 → EOF.
  - Accepted byte that makes count==MAX_FRAME with TxLast=0 → EOF with the forced flag set.
  - LinkEnable is ignored inside a frame.
- EOF:
  - Emit 8'hFD K=1 (K29.7). FrameErr=1 on the same output cycle if forced, else 0.
  - Go to IDLE phase 0. Bytes still offered after a forced EOF start a new frame through the normal IDLE phase-1 rule.
- Byte counter width: clog2(MAX_FRAME+1) bits; it never wraps.
- Simultaneous events: TxLast on byte number MAX_FRAME is a normal EOF (FrameErr=0). Reset has priority over every transition.

Optional Feature:
- Macro: TX_CLK_COMP_EN.
- Defined:
  - A character counter runs from the end of ALIGN (clog2(CC_PERIOD+1) bits, saturating).
  - When count>=CC_PERIOD and IDLE is in phase 1, the next state is CC instead of SOF or phase 0; CC has priority over a pending frame.
  - CC emits 8'h1C K=1 (K28.0) for exactly 2 cycles, clears the counter, then returns to IDLE phase 0. LinkUp stays high.
  - CC is never inserted inside a frame.
- Undefined: no CC state, no counter logic; CC_PERIOD is unused.

Test Plan:
- Reset=1 for 2 cycles, LinkEnable=1, TxValid=0 → 16 cycles of BC/K=1, then BC/K, 50/D alternating. LinkUp rises on the first idle BC.
- Frame 3D,99,0D,5F with TxLast on 5F, TxValid held high → outputs FB/K,3D,99,0D,5F,FD/K, then idle starting BC/K. TxReady high for exactly 4 cycles; FrameErr=0.
- Frame 1A,BA with TxValid low for 2 cycles between the bytes → FB/K,1A,F7/K,F7/K,BA,FD/K.
- MAX_FRAME=4, source offers 6 bytes with no TxLast → FB/K + 4 bytes, FD/K with FrameErr=1 for that one cycle. The remaining 2 bytes go out in a new frame after an idle ordered set.
- Reset asserted after the 2nd data byte → next cycle output BC/K, LinkUp=0, TxReady=0, ALIGN restarts; LinkEnable=0 in IDLE → commas only until re-enabled plus 16.
- TX_CLK_COMP_EN, CC_PERIOD=8, idle only → after 8 post-align characters, 1C/K, 1C/K inserted after a 50 character, then idle resumes with BC/K; a pending frame is delayed until after the CC pair.
